// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game engine.
// Board cells are addressed as a packed {y,x} position.
package snake_pkg;

  localparam int BOARD_W = 32;
  localparam int BOARD_H = 16;

  localparam logic [3:0] CELL_EMPTY = 4'd0;
  localparam logic [3:0] CELL_BODY  = 4'd1;
  localparam logic [3:0] CELL_FOOD  = 4'd2;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    S_CLEAR,
    S_INIT,
    S_IDLE,
    S_READ,
    S_CHECK,
    S_GROW,
    S_MOVE,
    S_ERASE,
    S_FOOD_RD,
    S_FOOD_CHK,
    S_DEAD
  } state_t;

  typedef struct packed {
    logic [3:0] y;
    logic [4:0] x;
  } pos_t;

  // x^9 + x^5 + 1 Fibonacci step
  function automatic logic [8:0] lfsr_step(
    input logic [8:0] s
  );
    return {s[7:0], s[8] ^ s[4]};
  endfunction

endpackage

// File: rtl/snake_if.sv
// Board RAM port bundle: write port plus synchronous read port.
// master = game engine, slave = dual-port board RAM.
interface snake_if;
  logic       wr_en;
  logic [4:0] wr_x;
  logic [3:0] wr_y;
  logic [3:0] wr_data;
  logic [4:0] rd_x;
  logic [3:0] rd_y;
  logic [3:0] rd_data;

  modport master (
    output wr_en, wr_x, wr_y, wr_data,
    output rd_x, rd_y,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_data,
    input  rd_x, rd_y,
    output rd_data
  );
endinterface

// File: rtl/snake_pos_fifo.sv
// Body position FIFO: tail at the read side, head is the last push.
// A push while full is accepted only together with a pop.
module snake_pos_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  pos_t                       din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output pos_t                       head,
  output pos_t                       tail
);

  localparam int AW = $clog2(DEPTH);

  pos_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign tail    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
        head   <= din;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game logic: owns the 32x16 board RAM write port.
// SNAKE_WRAP_EN: head wraps at the edges instead of hitting walls.
module snake_engine
  import snake_pkg::*;
#(
  parameter int         MAX_LEN   = 64,
  parameter logic [8:0] LFSR_SEED = 9'h1A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       restart,
  input  logic [1:0] dir,
  snake_if.master    ram,
  output logic       busy,
  output logic       game_over,
  output logic [6:0] length
);

  localparam int CW = $clog2(MAX_LEN) + 1;

  state_t        state;
  dir_t          cur_dir;
  dir_t          eff_dir;
  pos_t          nxt;
  pos_t          nh;
  pos_t          food_pos;
  pos_t          head;
  pos_t          tail;
  pos_t          init_pos;
  pos_t          fifo_din;
  pos_t          wr_pos;
  pos_t          rd_pos;
  logic [3:0]    wr_data_q;
  logic          wr_en_q;
  logic [8:0]    clr_cnt;
  logic [1:0]    init_idx;
  logic [8:0]    lfsr;
  logic          ate;
  logic          early_pop;
  logic          wall;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  assign eff_dir  = ((dir ^ cur_dir) == 2'b01) ? cur_dir : dir_t'(dir);
  assign init_pos = '{y: 4'd8, x: 5'd4 + {3'd0, init_idx}};

  always_comb begin
    nh   = head;
    wall = 1'b0;
    unique case (eff_dir)
      DIR_RIGHT: nh.x = head.x + 5'd1;
      DIR_LEFT:  nh.x = head.x - 5'd1;
      DIR_UP:    nh.y = head.y - 4'd1;
      default:   nh.y = head.y + 4'd1;
    endcase
`ifndef SNAKE_WRAP_EN
    unique case (eff_dir)
      DIR_RIGHT: wall = head.x == 5'(BOARD_W - 1);
      DIR_LEFT:  wall = head.x == 5'd0;
      DIR_UP:    wall = head.y == 4'd0;
      default:   wall = head.y == 4'(BOARD_H - 1);
    endcase
`endif
  end

  // At capacity a plain move pops together with its push
  assign push = (state == S_INIT) || (state == S_GROW)
             || (state == S_MOVE);
  assign pop  = !empty && (((state == S_MOVE) && full)
             || ((state == S_ERASE) && !early_pop));
  assign fifo_din = (state == S_INIT) ? init_pos : nxt;

  snake_pos_fifo #(
    .DEPTH (MAX_LEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (restart),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head),
    .tail  (tail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else
      lfsr <= lfsr_step(lfsr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      cur_dir   <= DIR_RIGHT;
      nxt       <= '0;
      food_pos  <= '0;
      clr_cnt   <= '0;
      init_idx  <= '0;
      ate       <= 1'b0;
      early_pop <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_pos    <= '0;
      wr_data_q <= CELL_EMPTY;
      rd_pos    <= '0;
      busy      <= 1'b1;
      game_over <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (restart) begin
        state     <= S_CLEAR;
        clr_cnt   <= '0;
        init_idx  <= '0;
        busy      <= 1'b1;
        game_over <= 1'b0;
      end else begin
        unique case (state)
          S_CLEAR: begin
            wr_en_q   <= 1'b1;
            wr_pos    <= clr_cnt;
            wr_data_q <= CELL_EMPTY;
            clr_cnt   <= clr_cnt + 9'd1;
            if (clr_cnt == 9'd511)
              state <= S_INIT;
          end
          S_INIT: begin
            wr_en_q   <= 1'b1;
            wr_pos    <= init_pos;
            wr_data_q <= CELL_BODY;
            init_idx  <= init_idx + 2'd1;
            cur_dir   <= DIR_RIGHT;
            if (init_idx == 2'd2) begin
              state    <= S_FOOD_RD;
              rd_pos   <= lfsr;
              food_pos <= lfsr;
            end
          end
          S_IDLE: begin
            if (tick) begin
              cur_dir <= eff_dir;
              if (wall) begin
                state     <= S_DEAD;
                game_over <= 1'b1;
              end else begin
                state  <= S_READ;
                nxt    <= nh;
                rd_pos <= nh;
                busy   <= 1'b1;
              end
            end
          end
          S_READ: state <= S_CHECK;
          S_CHECK: begin
            if (ram.rd_data == CELL_BODY) begin
              state     <= S_DEAD;
              game_over <= 1'b1;
              busy      <= 1'b0;
            end else begin
              wr_en_q   <= 1'b1;
              wr_pos    <= nxt;
              wr_data_q <= CELL_BODY;
              ate       <= ram.rd_data == CELL_FOOD;
              if (ram.rd_data == CELL_FOOD && !full)
                state <= S_GROW;
              else
                state <= S_MOVE;
            end
          end
          S_GROW: begin
            state    <= S_FOOD_RD;
            rd_pos   <= lfsr;
            food_pos <= lfsr;
          end
          S_MOVE: begin
            wr_en_q   <= 1'b1;
            wr_pos    <= tail;
            wr_data_q <= CELL_EMPTY;
            early_pop <= full;
            state     <= S_ERASE;
          end
          S_ERASE: begin
            if (ate) begin
              state    <= S_FOOD_RD;
              rd_pos   <= lfsr;
              food_pos <= lfsr;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_FOOD_RD: state <= S_FOOD_CHK;
          S_FOOD_CHK: begin
            // last INIT body write lands on the same edge as the read
            if (ram.rd_data == CELL_EMPTY && food_pos != head) begin
              wr_en_q   <= 1'b1;
              wr_pos    <= food_pos;
              wr_data_q <= CELL_FOOD;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              state    <= S_FOOD_RD;
              rd_pos   <= lfsr;
              food_pos <= lfsr;
            end
          end
          S_DEAD: state <= S_DEAD;
          default: state <= S_CLEAR;
        endcase
      end
    end
  end

  assign ram.wr_en   = wr_en_q;
  assign ram.wr_x    = wr_pos.x;
  assign ram.wr_y    = wr_pos.y;
  assign ram.wr_data = wr_data_q;
  assign ram.rd_x    = rd_pos.x;
  assign ram.rd_y    = rd_pos.y;
  assign length      = 7'(count);

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with a behavioural board RAM.
// Capacity is reduced to 4 so the full-length path is reachable.
module tb_snake_engine;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       restart;
  logic [1:0] dir;
  logic       busy;
  logic       game_over;
  logic [6:0] length;

  snake_if bus ();

  snake_engine #(
    .MAX_LEN   (4),
    .LFSR_SEED (9'h1A5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .restart   (restart),
    .dir       (dir),
    .ram       (bus),
    .busy      (busy),
    .game_over (game_over),
    .length    (length)
  );

  logic [3:0] mem [512];
  logic [3:0] rd_q;
  logic [8:0] last_food;
  logic [8:0] body_log [3];
  logic [8:0] wa;
  bit         food_seen;
  int         vectors;
  int         miscompares;
  int         wr_cnt;
  int         zero_cnt;
  int         body_cnt;
  int         food_cnt;
  int         bad_food;
  int         body_n;

  assign bus.rd_data = rd_q;
  assign wa = {bus.wr_y, bus.wr_x};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read-before-write, plus write bookkeeping
  always @(posedge clk) begin
    rd_q <= mem[{bus.rd_y, bus.rd_x}];
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      if (bus.wr_data == 4'd0)
        zero_cnt++;
      if (bus.wr_data == 4'd1) begin
        body_cnt++;
        if (body_n < 3)
          body_log[body_n] = wa;
        body_n++;
      end
      if (bus.wr_data == 4'd2) begin
        food_cnt++;
        if (mem[wa] != 4'd0)
          bad_food++;
        last_food = wa;
        food_seen = 1'b1;
      end
      mem[wa] = bus.wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    wr_cnt   = 0;
    zero_cnt = 0;
    body_cnt = 0;
    food_cnt = 0;
    bad_food = 0;
    body_n   = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 3000), 1);
    @(negedge clk);
    if (food_seen) begin
      mem[last_food] = 4'd0;
      food_seen = 1'b0;
    end
  endtask

  task automatic do_move(input string tag, input logic [1:0] d,
                         input int hx, input int hy,
                         input int tx, input int ty,
                         input int len, input logic to_food);
    @(negedge clk);
    tick = 1'b1;
    dir  = d;
    @(negedge clk);
    tick = 1'b0;
    chk({tag, "_rdx"}, bus.rd_x, hx);
    chk({tag, "_rdy"}, bus.rd_y, hy);
    @(negedge clk);
    chk({tag, "_c2we"}, bus.wr_en, 0);
    @(negedge clk);
    chk({tag, "_hwe"}, bus.wr_en, 1);
    chk({tag, "_hx"}, bus.wr_x, hx);
    chk({tag, "_hy"}, bus.wr_y, hy);
    chk({tag, "_hd"}, bus.wr_data, 1);
    @(negedge clk);
    chk({tag, "_twe"}, bus.wr_en, 1);
    chk({tag, "_tx"}, bus.wr_x, tx);
    chk({tag, "_ty"}, bus.wr_y, ty);
    chk({tag, "_td"}, bus.wr_data, 0);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 32'(to_food));
    chk({tag, "_len"}, length, len);
    if (to_food)
      wait_idle(tag);
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_zeros"}, zero_cnt, 512);
    chk({tag, "_bodies"}, body_cnt, 3);
    chk({tag, "_foods"}, food_cnt, 1);
    chk({tag, "_badfood"}, bad_food, 0);
    chk({tag, "_b0"}, body_log[0], 9'h104);
    chk({tag, "_b1"}, body_log[1], 9'h105);
    chk({tag, "_b2"}, body_log[2], 9'h106);
    chk({tag, "_len"}, length, 3);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int s;
    vectors     = 0;
    miscompares = 0;
    food_seen   = 1'b0;
    last_food   = '0;
    clr_stats();
    for (int i = 0; i < 512; i++)
      mem[i] = 4'd0;
    rst_n   = 1'b0;
    tick    = 1'b0;
    restart = 1'b0;
    dir     = 2'd0;

    @(negedge clk);
    chk("rst_we", bus.wr_en, 0);
    chk("rst_wx", bus.wr_x, 0);
    chk("rst_wy", bus.wr_y, 0);
    chk("rst_wd", bus.wr_data, 0);
    chk("rst_rx", bus.rd_x, 0);
    chk("rst_ry", bus.rd_y, 0);
    chk("rst_go", game_over, 0);
    chk("rst_len", length, 0);
    chk("rst_busy", busy, 1);
    rst_n = 1'b1;

    wait_idle("init");
    check_init("init");

    do_move("mv1", 2'd0, 7, 8, 4, 8, 3, 1'b0);

    clr_stats();
    mem[{4'd8, 5'd8}] = 4'd2;
    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd0;
    @(negedge clk);
    tick = 1'b0;
    chk("grow_rdx", bus.rd_x, 8);
    @(negedge clk);
    @(negedge clk);
    chk("grow_hwe", bus.wr_en, 1);
    chk("grow_hx", bus.wr_x, 8);
    chk("grow_hd", bus.wr_data, 1);
    @(negedge clk);
    chk("grow_noerase", bus.wr_en, 0);
    chk("grow_len", length, 4);
    chk("grow_busy", busy, 1);
    wait_idle("grow");
    chk("grow_foods", food_cnt, 1);
    chk("grow_zeros", zero_cnt, 0);
    chk("grow_badfood", bad_food, 0);

    clr_stats();
    mem[{4'd8, 5'd9}] = 4'd2;
    do_move("cap", 2'd0, 9, 8, 5, 8, 4, 1'b1);
    chk("cap_foods", food_cnt, 1);
    chk("cap_badfood", bad_food, 0);

    do_move("rev", 2'd1, 10, 8, 6, 8, 4, 1'b0);
    do_move("up", 2'd2, 10, 7, 7, 8, 4, 1'b0);
    do_move("left", 2'd1, 9, 7, 8, 8, 4, 1'b0);

    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd3;
    @(negedge clk);
    tick = 1'b0;
    chk("hit_rdx", bus.rd_x, 9);
    chk("hit_rdy", bus.rd_y, 8);
    @(negedge clk);
    chk("hit_go_c2", game_over, 0);
    @(negedge clk);
    chk("hit_go", game_over, 1);
    chk("hit_busy", busy, 0);
    chk("hit_we", bus.wr_en, 0);
    s = wr_cnt;
    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd0;
    @(negedge clk);
    tick = 1'b0;
    repeat (8) @(negedge clk);
    chk("dead_nowr", wr_cnt, s);
    chk("dead_go", game_over, 1);

    clr_stats();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_go", game_over, 0);
    chk("rs_busy", busy, 1);
    chk("rs_len", length, 0);
    wait_idle("rs");
    check_init("rs");

    clr_stats();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      tick = 1'b1;
      dir  = 2'd0;
      @(negedge clk);
      tick = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("walk_wr", wr_cnt, 50);
    chk("walk_len", length, 3);
    chk("walk_go", game_over, 0);
    chk("walk_busy", busy, 0);

`ifdef SNAKE_WRAP_EN
    do_move("wrap", 2'd0, 0, 8, 29, 8, 3, 1'b0);
    chk("wrap_go", game_over, 0);
`else
    @(negedge clk);
    tick = 1'b1;
    dir  = 2'd0;
    s = wr_cnt;
    @(negedge clk);
    tick = 1'b0;
    chk("wall_go", game_over, 1);
    chk("wall_busy", busy, 0);
    chk("wall_rdx", bus.rd_x, 31);
    chk("wall_rdy", bus.rd_y, 8);
    chk("wall_we", bus.wr_en, 0);
    repeat (4) @(negedge clk);
    chk("wall_nowr", wr_cnt, s);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
